// File: rtl/apb_loader_pkg.sv
// Shared types and default widths for the APB image loader.
package apb_loader_pkg;

    localparam int AMBA_WORD_DEF       = 24;
    localparam int AMBA_ADDR_DEPTH_DEF = 12;
    localparam int RESULT_ADDR_DEF     = 4095;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_DATA = 3'd1,
        SETUP     = 3'd2,
        ACCESS    = 3'd3,
        RD_SETUP  = 3'd4,
        RD_ACCESS = 3'd5,
        DONE      = 3'd6
    } state_t;

    // True in the states that drive an APB transfer (PSEL high).
    function automatic logic is_bus_state(input state_t s);
        return (s == SETUP) || (s == ACCESS) || (s == RD_SETUP) || (s == RD_ACCESS);
    endfunction

endpackage

// File: rtl/apb_image_loader_if.sv
// Bundle of the APB requester signals and the pixel stream handshake.
interface apb_image_loader_if
    import apb_loader_pkg::*;
#(
    parameter int Amba_Word       = AMBA_WORD_DEF,
    parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH_DEF
) ();
    logic [Amba_Addr_Depth-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [Amba_Word-1:0]       PWDATA;
    logic [Amba_Word-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;
    logic                       pix_valid;
    logic [Amba_Word-1:0]       pix_data;
    logic                       pix_ready;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA, pix_ready,
        input  PRDATA, PREADY, PSLVERR, pix_valid, pix_data
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA, pix_ready,
        output PRDATA, PREADY, PSLVERR, pix_valid, pix_data
    );
endinterface

// File: rtl/apb_addr_counter.sv
// Holds base address, pixel count and write index; produces base+index
// (wrapping) and a flag saying the current index is the final pixel.
module apb_addr_counter
    import apb_loader_pkg::*;
#(
    parameter int Addr_W = AMBA_ADDR_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              inc,
    input  logic [Addr_W-1:0] base_in,
    input  logic [Addr_W-1:0] num_in,
    output logic [Addr_W-1:0] addr,
    output logic              last
);
    logic [Addr_W-1:0] base_q, base_d;
    logic [Addr_W-1:0] num_q,  num_d;
    logic [Addr_W-1:0] idx_q,  idx_d;

    // Next-state for the latched parameters and the running index.
    always_comb begin
        base_d = base_q;
        num_d  = num_q;
        idx_d  = idx_q;
        if (load) begin
            base_d = base_in;
            num_d  = num_in;
            idx_d  = '0;
        end else if (inc) begin
            idx_d  = idx_q + {{(Addr_W-1){1'b0}}, 1'b1};
        end else begin
            idx_d  = idx_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            base_q <= '0;
            num_q  <= '0;
            idx_q  <= '0;
        end else begin
            base_q <= base_d;
            num_q  <= num_d;
            idx_q  <= idx_d;
        end
    end

    assign addr = base_q + idx_q;
    // Compared one bit wider so index+1 cannot wrap at the top of the range.
    assign last = (({1'b0, idx_q}) + (Addr_W+1)'(1)) >= {1'b0, num_q};

endmodule

// File: rtl/apb_image_loader.sv
// Streams pixel words into consecutive APB addresses, then reads back a
// single result word from a fixed address.
module apb_image_loader
    import apb_loader_pkg::*;
#(
    parameter int Amba_Word       = AMBA_WORD_DEF,
    parameter int Amba_Addr_Depth = AMBA_ADDR_DEPTH_DEF,
    parameter int Result_Addr     = RESULT_ADDR_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [Amba_Addr_Depth-1:0] base_addr,
    input  logic [Amba_Addr_Depth-1:0] num_words,
    input  logic                       pix_valid,
    input  logic [Amba_Word-1:0]       pix_data,
    output logic                       pix_ready,
    output logic [Amba_Addr_Depth-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Word-1:0]       PWDATA,
    input  logic [Amba_Word-1:0]       PRDATA,
    input  logic                       PREADY,
    input  logic                       PSLVERR,
    output logic                       busy,
    output logic                       done,
    output logic [Amba_Word-1:0]       result,
    output logic                       err
);
    localparam logic [Amba_Addr_Depth-1:0] RES_ADDR = Amba_Addr_Depth'(Result_Addr);

    state_t                     state_q, state_d;
    logic [Amba_Word-1:0]       pwdata_q, pwdata_d;
    logic [Amba_Word-1:0]       result_q, result_d;
    logic                       err_q, err_d;
    logic                       cnt_load_s, cnt_inc_s, cnt_last_s;
    logic [Amba_Addr_Depth-1:0] cnt_addr_s;

    apb_addr_counter #(.Addr_W(Amba_Addr_Depth)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load_s),
        .inc     (cnt_inc_s),
        .base_in (base_addr),
        .num_in  (num_words),
        .addr    (cnt_addr_s),
        .last    (cnt_last_s)
    );

    // Next-state logic and datapath updates of the load sequencer.
    always_comb begin
        state_d    = state_q;
        pwdata_d   = pwdata_q;
        result_d   = result_q;
        err_d      = err_q;
        cnt_load_s = 1'b0;
        cnt_inc_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cnt_load_s = 1'b1;
                    err_d      = 1'b0;
                    state_d    = (num_words == '0) ? RD_SETUP : WAIT_DATA;
                end else begin
                    state_d    = IDLE;
                end
            end
            WAIT_DATA: begin
                if (pix_valid) begin
                    pwdata_d = pix_data;
                    state_d  = SETUP;
                end else begin
                    state_d  = WAIT_DATA;
                end
            end
            SETUP:    state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    cnt_inc_s = 1'b1;
                    err_d     = err_q | PSLVERR;
                    state_d   = cnt_last_s ? RD_SETUP : WAIT_DATA;
                end else begin
                    state_d   = ACCESS;
                end
            end
            RD_SETUP: state_d = RD_ACCESS;
            RD_ACCESS: begin
                if (PREADY) begin
                    result_d = PRDATA;
                    err_d    = err_q | PSLVERR;
                    state_d  = DONE;
                end else begin
                    state_d  = RD_ACCESS;
                end
            end
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            pwdata_q <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwdata_q <= pwdata_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Every output is a register or a pure decode of state_q.
    assign PSEL      = is_bus_state(state_q);
    assign PENABLE   = (state_q == ACCESS) || (state_q == RD_ACCESS);
    assign PWRITE    = (state_q == SETUP) || (state_q == ACCESS);
    assign PADDR     = ((state_q == RD_SETUP) || (state_q == RD_ACCESS)) ? RES_ADDR : cnt_addr_s;
    assign PWDATA    = pwdata_q;
    assign pix_ready = (state_q == WAIT_DATA);
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign err       = err_q;

endmodule

// File: tb/tb_apb_image_loader.sv
// Directed, table-driven bench for apb_image_loader with an APB completer model.
module tb_apb_image_loader;
    import apb_loader_pkg::*;

    typedef struct packed {
        logic [11:0]       base;
        logic [11:0]       num;
        logic [2:0][23:0]  pix;
        int                stall;
        int                err_idx;
        logic [23:0]       prdata;
        logic [23:0]       exp_result;
        logic              exp_err;
        logic [2:0][11:0]  exp_addr;
        int                exp_cycles;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [11:0] num_words;
    logic        busy;
    logic        done;
    logic [23:0] result;
    logic        err;

    int n_checks;
    int n_fail;

    apb_image_loader_if #(.Amba_Word(24), .Amba_Addr_Depth(12)) bus ();

    apb_image_loader #(.Amba_Word(24), .Amba_Addr_Depth(12), .Result_Addr(4095)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .pix_valid (bus.pix_valid),
        .pix_data  (bus.pix_data),
        .pix_ready (bus.pix_ready),
        .PADDR     (bus.PADDR),
        .PSEL      (bus.PSEL),
        .PENABLE   (bus.PENABLE),
        .PWRITE    (bus.PWRITE),
        .PWDATA    (bus.PWDATA),
        .PRDATA    (bus.PRDATA),
        .PREADY    (bus.PREADY),
        .PSLVERR   (bus.PSLVERR),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [11:0] base, input logic [11:0] num,
                                input logic [23:0] p0, input logic [23:0] p1, input logic [23:0] p2,
                                input int stall, input int err_idx, input logic [23:0] prdata,
                                input logic [23:0] res, input logic e,
                                input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                                input int cyc);
        vec_t v;
        v.base = base; v.num = num;
        v.pix[0] = p0; v.pix[1] = p1; v.pix[2] = p2;
        v.stall = stall; v.err_idx = err_idx; v.prdata = prdata;
        v.exp_result = res; v.exp_err = e;
        v.exp_addr[0] = a0; v.exp_addr[1] = a1; v.exp_addr[2] = a2;
        v.exp_cycles = cyc;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int          cycles, wr_n, rd_n, acc0, stall_left;
        logic [11:0] cap_addr;
        logic [23:0] cap_data;
        logic        cap_wr;
        bit          fin;
        cycles = 0; wr_n = 0; rd_n = 0; acc0 = 0; stall_left = v.stall; fin = 1'b0;
        cap_addr = '0; cap_data = '0; cap_wr = 1'b0;
        @(negedge clk);
        base_addr = v.base; num_words = v.num; start = 1'b1;
        bus.pix_valid = 1'b1; bus.pix_data = v.pix[0]; bus.PRDATA = v.prdata;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 100 && !fin; c++) begin
            if (busy) cycles++;
            if (done) fin = 1'b1;
            bus.PREADY = 1'b1;
            bus.PSLVERR = 1'b0;
            if (bus.PSEL && bus.PENABLE) begin
                if (bus.PWRITE) begin
                    if (wr_n == 0) begin
                        if (acc0 == 0) begin
                            cap_addr = bus.PADDR; cap_data = bus.PWDATA; cap_wr = bus.PWRITE;
                        end else begin
                            chk($sformatf("v%0d stall PADDR", id), bus.PADDR, cap_addr);
                            chk($sformatf("v%0d stall PWDATA", id), bus.PWDATA, cap_data);
                            chk($sformatf("v%0d stall PWRITE", id), bus.PWRITE, cap_wr);
                        end
                        acc0++;
                    end
                    if (wr_n == 0 && stall_left > 0) begin
                        bus.PREADY = 1'b0;
                        stall_left--;
                    end else begin
                        bus.PSLVERR = (wr_n == v.err_idx);
                        if (wr_n < 3) begin
                            chk($sformatf("v%0d wr%0d addr", id, wr_n), bus.PADDR, v.exp_addr[wr_n]);
                            chk($sformatf("v%0d wr%0d data", id, wr_n), bus.PWDATA, v.pix[wr_n]);
                        end
                        wr_n++;
                    end
                end else begin
                    chk($sformatf("v%0d rd addr", id), bus.PADDR, 12'hFFF);
                    rd_n++;
                end
            end
            if (bus.pix_ready && wr_n < 3) bus.pix_data = v.pix[wr_n];
            if (!fin) @(negedge clk);
        end
        bus.pix_valid = 1'b0;
        bus.PREADY = 1'b1;
        bus.PSLVERR = 1'b0;
        chk($sformatf("v%0d done seen", id), fin, 1'b1);
        chk($sformatf("v%0d cycles", id), cycles, v.exp_cycles);
        chk($sformatf("v%0d write count", id), wr_n, v.num);
        chk($sformatf("v%0d read count", id), rd_n, 32'd1);
        if (v.stall > 0) chk($sformatf("v%0d access cycles", id), acc0, v.stall + 1);
        @(negedge clk);
        chk($sformatf("v%0d done pulse end", id), done, 1'b0);
        chk($sformatf("v%0d busy end", id), busy, 1'b0);
        chk($sformatf("v%0d PSEL end", id), bus.PSEL, 1'b0);
        chk($sformatf("v%0d result", id), result, v.exp_result);
        chk($sformatf("v%0d err", id), err, v.exp_err);
    endtask

    vec_t vecs [6];

    initial begin
        n_checks = 0; n_fail = 0;
        vecs[0] = mk(12'h010, 12'd2, 24'hABCDEF, 24'h123456, 24'h0, 0, -1, 24'h000001, 24'h000001, 1'b0,
                     12'h010, 12'h011, 12'h000, 9);
        vecs[1] = mk(12'h020, 12'd2, 24'h111111, 24'h222222, 24'h0, 3, -1, 24'h00BEEF, 24'h00BEEF, 1'b0,
                     12'h020, 12'h021, 12'h000, 12);
        vecs[2] = mk(12'h030, 12'd0, 24'h0, 24'h0, 24'h0, 0, -1, 24'h0C0FFE, 24'h0C0FFE, 1'b0,
                     12'h000, 12'h000, 12'h000, 3);
        vecs[3] = mk(12'hFFE, 12'd3, 24'h000001, 24'h000002, 24'h000003, 0, -1, 24'h777777, 24'h777777, 1'b0,
                     12'hFFE, 12'hFFF, 12'h000, 12);
        vecs[4] = mk(12'h040, 12'd2, 24'h00000A, 24'h00000B, 24'h0, 0, 1, 24'h222222, 24'h222222, 1'b1,
                     12'h040, 12'h041, 12'h000, 9);
        vecs[5] = mk(12'h050, 12'd1, 24'hC0C0C0, 24'h0, 24'h0, 0, -1, 24'h333333, 24'h333333, 1'b0,
                     12'h050, 12'h000, 12'h000, 6);

        rst = 1'b0; start = 1'b0; base_addr = '0; num_words = '0;
        bus.pix_valid = 1'b0; bus.pix_data = '0; bus.PRDATA = '0; bus.PREADY = 1'b1; bus.PSLVERR = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset PSEL", bus.PSEL, 1'b0);
        chk("reset PENABLE", bus.PENABLE, 1'b0);
        chk("reset PADDR", bus.PADDR, 12'h000);
        chk("reset PWDATA", bus.PWDATA, 24'h0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result", result, 24'h0);
        chk("reset err", err, 1'b0);
        chk("reset pix_ready", bus.pix_ready, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        repeat (3) @(negedge clk);
        chk("result held", result, 24'h333333);

        // Pixel stall, start while busy, then reset in the middle of ACCESS.
        base_addr = 12'h100; num_words = 12'd1; start = 1'b1; bus.pix_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall pix_ready", bus.pix_ready, 1'b1);
            chk("stall PSEL", bus.PSEL, 1'b0);
            @(negedge clk);
        end
        base_addr = 12'h200; num_words = 12'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy start ignored", bus.pix_ready, 1'b1);
        chk("busy start PSEL", bus.PSEL, 1'b0);
        bus.pix_data = 24'h55AA33; bus.pix_valid = 1'b1; bus.PREADY = 1'b0;
        @(negedge clk);
        bus.pix_valid = 1'b0;
        chk("setup PSEL", bus.PSEL, 1'b1);
        chk("setup PENABLE", bus.PENABLE, 1'b0);
        chk("setup PWRITE", bus.PWRITE, 1'b1);
        chk("setup PADDR", bus.PADDR, 12'h100);
        chk("setup PWDATA", bus.PWDATA, 24'h55AA33);
        @(negedge clk);
        chk("access PENABLE", bus.PENABLE, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid rst PSEL", bus.PSEL, 1'b0);
        chk("mid rst PENABLE", bus.PENABLE, 1'b0);
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst done", done, 1'b0);
        chk("mid rst PADDR", bus.PADDR, 12'h000);
        chk("mid rst PWDATA", bus.PWDATA, 24'h0);
        chk("mid rst result", result, 24'h0);
        rst = 1'b1; bus.PREADY = 1'b1;
        @(negedge clk);
        chk("after rst idle", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_image_loader.md
APB_IMAGE_LOADER -- requirements
Module: apb_image_loader

Interface
REQ-001 The module SHALL have parameter Amba_Word, default 24, meaning APB data width in bits.
REQ-002 The module SHALL have parameter Amba_Addr_Depth, default 12, meaning APB address width in bits.
REQ-003 The module SHALL have parameter Result_Addr, default all-ones (4095), meaning the address read after the image is loaded.
REQ-004 Ports SHALL be exactly as follows, one per line: name, direction, width, meaning.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  input  Amba_Addr_Depth  first pixel address; sampled with start.
- num_words  input  Amba_Addr_Depth  pixel count; sampled with start.
- pix_valid  input  1  pixel word available.
- pix_data  input  Amba_Word  pixel word.
- pix_ready  output  1  loader accepts pix_data this cycle.
- PADDR  output  Amba_Addr_Depth  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction; 1 means write.
- PWDATA  output  Amba_Word  APB write data.
- PRDATA  input  Amba_Word  APB read data.
- PREADY  input  1  APB completer ready; tie high for zero-wait completers.
- PSLVERR  input  1  APB completer error.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the load completes.
- result  output  Amba_Word  PRDATA captured from the Result_Addr read.
- err  output  1  sticky; set if PSLVERR is seen on any completed transfer.

Function
REQ-005 The FSM SHALL have the states IDLE, WAIT_DATA, SETUP, ACCESS, RD_SETUP, RD_ACCESS and DONE.
REQ-006 In IDLE, start=1 SHALL latch base_addr and num_words, clear err, and move to WAIT_DATA; if num_words=0 it SHALL move to RD_SETUP instead.
REQ-007 In WAIT_DATA, pix_ready SHALL be 1, and pix_ready SHALL be 0 in every other state.
REQ-008 In WAIT_DATA, pix_valid=1 SHALL register pix_data into PWDATA and move to SETUP.
REQ-009 In SETUP, the outputs SHALL be PSEL=1, PENABLE=0, PWRITE=1 and PADDR=base+index, and the FSM SHALL move to ACCESS unconditionally.
REQ-010 In ACCESS, the outputs SHALL be PSEL=1 and PENABLE=1, and PADDR, PWDATA and PWRITE SHALL be held stable while PREADY=0.
REQ-011 When ACCESS sees PREADY=1, the transfer SHALL complete and index SHALL increment; the FSM SHALL go to WAIT_DATA if index+1<num_words, else to RD_SETUP.
REQ-012 RD_SETUP and RD_ACCESS SHALL behave like SETUP and ACCESS except PWRITE=0 and PADDR=Result_Addr.
REQ-013 When RD_ACCESS sees PREADY=1, PRDATA SHALL be captured into result and the FSM SHALL move to DONE.
REQ-014 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-015 Address arithmetic SHALL be modulo 2^Amba_Addr_Depth, with silent wrap-around (base 4094 + index 3 gives 1).
REQ-016 The minimum throughput SHALL be 3 cycles per pixel with PREADY=1 and pix_valid held high.
REQ-017 PSEL SHALL never deassert between SETUP and the completing ACCESS cycle.
REQ-018 PSLVERR sampled with PREADY=1 in ACCESS or RD_ACCESS SHALL set err, and the load SHALL continue regardless.
REQ-019 start SHALL be ignored when busy=1.
REQ-020 A pix_valid drop in WAIT_DATA SHALL stall the FSM in WAIT_DATA with PSEL=0.
REQ-021 In IDLE, WAIT_DATA and DONE, PSEL and PENABLE SHALL be 0.
REQ-022 result SHALL hold its value until the next completed read.

Reset
REQ-023 When rst=0 at a rising clk edge, the FSM SHALL go to IDLE and all outputs, index and latched inputs SHALL be zero, including during a transfer in progress.
REQ-024 A reset taken mid-transfer SHALL drop PSEL and PENABLE in the next cycle, with no attempt to finish the transfer.

Structure
REQ-025 A shared package apb_loader_pkg SHALL hold the state enum, the default widths, and the Result_Addr default.
REQ-026 The address/index counter SHALL be the single sub-module apb_addr_counter (load, increment, last-flag compare).
REQ-027 All outputs SHALL be registered or decoded from the state register only, with no combinational path from PRDATA to any output.

Verification
REQ-028 start, base=0x010, num=2, pixels 0xABCDEF and 0x123456, PREADY=1 -> two writes (0x010 gets 0xABCDEF, 0x011 gets 0x123456), then a read of 0xFFF; PRDATA=0x000001 gives result=1, done pulses, and the whole load takes 9 cycles.
REQ-029 PREADY low for 3 cycles in the first ACCESS -> PADDR, PWDATA and PWRITE stay stable for 4 ACCESS cycles, and PSEL stays high throughout.
REQ-030 num=0 -> no write transfers, only a read of 0xFFF, then done.
REQ-031 base=0xFFE, num=3 -> write addresses are 0xFFE, 0xFFF, 0x000.
REQ-032 PSLVERR=1 on the second write -> err=1 and the load still completes; err clears on the next start.
REQ-033 rst=0 during ACCESS -> the next cycle shows PSEL=0, busy=0 and done=0, and start is ignored while busy=1.
